inst_encoder: RTL and testbench
===============================

# inst_encoder

- Pipelined RV32I instruction encoder: accepts decoded fields (format, opcode, register indices, funct bits, 32-bit immediate) and packs them into a 32-bit instruction word.
- Performs the inverse of the ID-stage immediate generator, scattering the immediate into the S/B/U/J/I bit positions.
- Emits each word with a sequential instruction-memory address. Feeds the boot/self-test loader that writes programs into instruction memory.

## Interface
Parameters:
- ADDR_W, 10, width of the word-address counter.
- BASE_ADDR, 0, counter value after reset and after `clear`.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of pipeline and counter
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- opcode  in  7
- rd, rs1, rs2  in  5 each
- funct3  in  3
- funct7  in  7
- imm  in  32  byte-offset immediate, signed (not pre-shifted)
- out_valid  out  1
- out_ready  in  1
- inst  out  32  encoded word
- addr  out  ADDR_W  word address for `inst`
- err  out  1  this word failed checking (see Configuration)

## Operation
- Two register stages:
  - S1 captures fields on `in_valid && in_ready`.
  - S2 (output) captures the packed word, `err` and the counter value.
- Field placement per format:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Fields a format does not use are ignored.
- Counter:
  - Loads into `addr` with each S2 load, then increments.
  - Wraps from 2^ADDR_W-1 to 0.
  - Erroneous words still consume an address.
- Illegal `fmt` (6/7) always gives `inst`=0x00000013 (NOP) and `err`=1, with or without the macro.

## Timing
- Reset values: `out_valid`=0, `inst`=0, `addr`=0, `err`=0, S1 empty, counter=BASE_ADDR.
- `in_ready`=1 while out of reset.
- Latency: a word accepted at edge N drives `out_valid`=1 after edge N+1. Throughput is 1 word/cycle while `out_ready`=1.
- S2 loads when `!out_valid || out_ready`. S1 advances when S2 loads.
- `in_ready` = !S1 valid || S2 loads. It is combinational from `out_ready`.
- While `out_valid && !out_ready`, `inst`, `addr` and `err` are held stable.
- `clear`:
  - Forces `in_ready`=0 and drops any input that cycle.
  - Empties S1 and S2 and reloads the counter to BASE_ADDR.
  - Takes priority over a simultaneous output handshake.
- Reset mid-stream discards all in-flight words immediately (asynchronous).

## Configuration
- `INST_ENC_CHECK_EN` defined: the immediate is range- and alignment-checked.
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and even.
  - J: imm in [-2^20, 2^20-2] and even.
  - U: imm[11:0]==0.
  - R: no check.
  - On failure, `inst`=0x00000013 and `err`=1.
- Undefined: no immediate checks. Immediate bits are truncated or dropped silently. `err` is set only for illegal `fmt`.

## Structure
- Shared constants go in riscv_def.v: fmt codes (`FMT_R`..`FMT_J`), the NOP word 0x00000013, and field width macros.
- One sub-module, `inst_pack`: combinational packing plus checking. It is instantiated between S1 and S2.

## Test plan
- I-type (addi x1,x0,5): fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5. Expect `inst`=0x00500093, `addr`=0, `out_valid` two edges after accept.
- S-type (sw x2,8(x1)): fmt=2, opcode=0x23, rs1=1, rs2=2, funct3=2, imm=8. Expect 0x0020A423.
- B and J:
  - beq x0,x0,-4 (opcode=0x63, imm=-4) → 0xFE000EE3.
  - jal x1,2048 (opcode=0x6F, rd=1, imm=0x800) → 0x001000EF.
- Check path, fmt=3 with imm=3 (odd):
  - With `INST_ENC_CHECK_EN`: `inst`=0x00000013, `err`=1.
  - Without it: bit 0 is dropped, `err`=0.
  - fmt=7 gives NOP and `err`=1 in both builds.
- Backpressure: hold `out_ready`=0 and offer 3 words. Expect `in_ready` to drop after 2 accepts and `inst` to stay stable. Releasing `out_ready` yields addrs 0, 1, 2 in order with no loss.
- Wrap and clear:
  - ADDR_W=2, 5 words → addrs 0, 1, 2, 3, 0.
  - `clear` mid-stream → pipeline empties, next word has addr=BASE_ADDR.
  - `rst` low mid-stream → `out_valid`=0 immediately.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared constants, field bundle and immediate helper for the RV32I instruction encoder.
// INST_ENC_CHECK_EN (optional) enables immediate range/alignment checking in inst_pack.
package inst_encoder_pkg;

  localparam int OPCODE_W = 7;
  localparam int REG_W    = 5;
  localparam int F3_W     = 3;
  localparam int F7_W     = 7;
  localparam int FMT_W    = 3;

  localparam logic [FMT_W-1:0] FMT_R = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [FMT_W-1:0]    fmt;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [F3_W-1:0]     funct3;
    logic [F7_W-1:0]     funct7;
    logic [31:0]         imm;
  } fields_t;

  localparam int FIELDS_W = $bits(fields_t);

  // True when v is representable as an nbits-wide two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
    logic [31:0] ext_s;
    ext_s = 32'($signed(v) >>> (nbits - 32'd1));
    return (ext_s == 32'h0000_0000) || (ext_s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational RV32I field packing with illegal-format and optional
// immediate checking (INST_ENC_CHECK_EN). Any failure yields the NOP word.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  fields_t     fields,
  output logic [31:0] inst,
  output logic        err
);

  logic [31:0] raw_s;
  logic        bad_fmt_s;
  logic        bad_imm_s;
  logic [31:0] imm_s;

  assign imm_s = fields.imm;

  // Scatter fields and immediate bits into the word layout of each format.
  always_comb begin
    raw_s     = NOP_INST;
    bad_fmt_s = 1'b0;
    case (fields.fmt)
      FMT_R: raw_s = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
      FMT_I: raw_s = {imm_s[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
      FMT_S: raw_s = {imm_s[11:5], fields.rs2, fields.rs1, fields.funct3, imm_s[4:0], fields.opcode};
      FMT_B: raw_s = {imm_s[12], imm_s[10:5], fields.rs2, fields.rs1, fields.funct3,
                      imm_s[4:1], imm_s[11], fields.opcode};
      FMT_U: raw_s = {imm_s[31:12], fields.rd, fields.opcode};
      FMT_J: raw_s = {imm_s[20], imm_s[10:1], imm_s[11], imm_s[19:12], fields.rd, fields.opcode};
      default: begin
        raw_s     = NOP_INST;
        bad_fmt_s = 1'b1;
      end
    endcase
  end

`ifdef INST_ENC_CHECK_EN
  // Reject immediates the chosen format cannot represent exactly.
  always_comb begin
    bad_imm_s = 1'b0;
    case (fields.fmt)
      FMT_I, FMT_S: bad_imm_s = !fits_signed(imm_s, 32'd12);
      FMT_B:        bad_imm_s = !fits_signed(imm_s, 32'd13) || imm_s[0];
      FMT_J:        bad_imm_s = !fits_signed(imm_s, 32'd21) || imm_s[0];
      FMT_U:        bad_imm_s = (imm_s[11:0] != 12'h000);
      default:      bad_imm_s = 1'b0;
    endcase
  end
`else
  assign bad_imm_s = 1'b0;
`endif

  assign err  = bad_fmt_s || bad_imm_s;
  assign inst = err ? NOP_INST : raw_s;

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: two-stage RV32I encoder emitting packed words with sequential word addresses.
// Build option INST_ENC_CHECK_EN turns on immediate checking inside inst_pack.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          fmt,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [31:0]         imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         inst,
  output logic [ADDR_W-1:0]   addr,
  output logic                err
);

  fields_t             in_fields_s;
  fields_t             s1_fields_q, s1_fields_d;
  logic                s1_valid_q, s1_valid_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         inst_q, inst_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [31:0]         pack_inst_s;
  logic                pack_err_s;
  logic                s2_load_s;
  logic                in_ready_s;
  logic                accept_s;

  assign in_fields_s = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                         funct3: funct3, funct7: funct7, imm: imm};

  assign s2_load_s  = !out_valid_q || out_ready;
  assign in_ready_s = rst && !clear && (!s1_valid_q || s2_load_s);
  assign accept_s   = in_valid && in_ready_s;

  inst_pack u_pack (
    .fields (s1_fields_q),
    .inst   (pack_inst_s),
    .err    (pack_err_s)
  );

  // Next-state for both stages and the address counter; clear overrides any handshake.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fields_d = s1_fields_q;
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    err_d       = err_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    if (clear) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      inst_d      = 32'h0000_0000;
      err_d       = 1'b0;
      addr_d      = {ADDR_W{1'b0}};
      cnt_d       = BASE_ADDR;
    end else begin
      if (s2_load_s) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          inst_d = pack_inst_s;
          err_d  = pack_err_s;
          addr_d = cnt_q;
          cnt_d  = cnt_q + ADDR_W'(1);
        end else begin
          inst_d = inst_q;
        end
      end else begin
        out_valid_d = out_valid_q;
      end
      if (accept_s) begin
        s1_valid_d  = 1'b1;
        s1_fields_d = in_fields_s;
      end else if (s2_load_s) begin
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = s1_valid_q;
      end
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_fields_q <= fields_t'({FIELDS_W{1'b0}});
      out_valid_q <= 1'b0;
      inst_q      <= 32'h0000_0000;
      err_q       <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      cnt_q       <= BASE_ADDR;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fields_q <= s1_fields_d;
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign inst      = inst_q;
  assign addr      = addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: two instances (default and 2-bit counter with
// nonzero base) share stimulus and are compared against an arithmetic reference model.
module tb_inst_encoder;

  localparam logic [9:0] BASE0 = 10'd0;
  localparam logic [1:0] BASE1 = 2'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, in_valid, out_ready;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        in_ready0, out_valid0, err0, in_ready1, out_valid1, err1;
  logic [31:0] inst0, inst1;
  logic [9:0]  addr0;
  logic [1:0]  addr1;

  inst_encoder #(.ADDR_W(10), .BASE_ADDR(BASE0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid0), .out_ready(out_ready),
    .inst(inst0), .addr(addr0), .err(err0)
  );

  inst_encoder #(.ADDR_W(2), .BASE_ADDR(BASE1)) dut_w (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid1), .out_ready(out_ready),
    .inst(inst1), .addr(addr1), .err(err1)
  );

  typedef struct { logic [31:0] inst; logic err; } exp_t;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t q[$];
  int   k;
  bit   last_acc;
  bit   acc;
  int   n_emitted;
  logic [31:0] last_inst;
  logic        last_err;
  int   log0[$];
  int   log1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference encoder built from the format rules with shifts and masks on integers.
  function automatic exp_t model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] im);
    exp_t        e;
    bit   [31:0] u;
    bit   [31:0] base;
    longint      si;
    bit          bad;
    u    = im;
    si   = longint'($signed(im));
    bad  = 1'b0;
    base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    e.err = 1'b0;
    case (f)
      3'd0: e.inst = (32'(f7) << 25) | (32'(s2) << 20) | base | (32'(d) << 7);
      3'd1: e.inst = ((u & 32'hFFF) << 20) | base | (32'(d) << 7);
      3'd2: e.inst = (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base | ((u & 32'h1F) << 7);
      3'd3: e.inst = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                     | base | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
      3'd4: e.inst = (u & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
      3'd5: e.inst = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                     | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                     | (32'(d) << 7) | 32'(op);
      default: bad = 1'b1;
    endcase
`ifdef INST_ENC_CHECK_EN
    case (f)
      3'd1, 3'd2: if (si < -2048 || si > 2047) bad = 1'b1;
      3'd3: if (si < -4096 || si > 4094 || u[0]) bad = 1'b1;
      3'd5: if (si < -(64'sd1 << 20) || si > (64'sd1 << 20) - 2 || u[0]) bad = 1'b1;
      3'd4: if ((u & 32'hFFF) != 32'h0) bad = 1'b1;
      default: ;
    endcase
`endif
    if (bad) begin
      e.inst = 32'h0000_0013;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  // One clock: check outputs against the model, then advance model across the edge.
  task automatic run_cycle();
    bit   ir_m, ov_m, fire;
    int   occ;
    exp_t nw;
    #1;
    occ  = q.size();
    ir_m = !clear && (occ < 2 || out_ready);
    ov_m = (occ >= 2) || (occ == 1 && !last_acc);
    chk("in_ready", 64'(in_ready0), 64'(ir_m));
    chk("in_ready_w", 64'(in_ready1), 64'(ir_m));
    chk("out_valid", 64'(out_valid0), 64'(ov_m));
    chk("out_valid_w", 64'(out_valid1), 64'(ov_m));
    if (ov_m) begin
      chk("inst", 64'(inst0), 64'(q[0].inst));
      chk("err", 64'(err0), 64'(q[0].err));
      chk("addr", 64'(addr0), 64'((int'(BASE0) + k) % 1024));
      chk("inst_w", 64'(inst1), 64'(q[0].inst));
      chk("addr_w", 64'(addr1), 64'((int'(BASE1) + k) % 4));
    end
    fire = ov_m && out_ready && !clear;
    acc  = in_valid && ir_m;
    nw   = model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
    if (fire) begin
      last_inst = inst0;
      last_err  = err0;
      log0.push_back(int'(addr0));
      log1.push_back(int'(addr1));
      n_emitted++;
    end
    @(posedge clk);
    if (clear) begin
      q.delete();
      k        = 0;
      last_acc = 1'b0;
    end else begin
      if (fire) begin
        void'(q.pop_front());
        k++;
      end
      if (acc) q.push_back(nw);
      last_acc = acc;
    end
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Offer one word until accepted, then wait (bounded) for it to be emitted and compare.
  task automatic send(input string tag, input logic [2:0] f, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3, input logic [31:0] im,
                      input logic [31:0] exp_inst, input logic exp_err);
    int n0;
    set_fields(f, op, d, s1, s2, f3, 7'h00, im);
    in_valid = 1'b1;
    out_ready = 1'b1;
    n0 = n_emitted;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      if (acc) break;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (n_emitted > n0) break;
      run_cycle();
    end
    chk({tag, "_emitted"}, 64'(n_emitted > n0), 64'd1);
    chk({tag, "_inst"}, 64'(last_inst), 64'(exp_inst));
    chk({tag, "_err"}, 64'(last_err), 64'(exp_err));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    in_valid = 1'b1;
    run_cycle();
    clear = 1'b0;
    in_valid = 1'b0;
    log0.delete();
    log1.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid0), 64'd0);
    chk({tag, "_out_valid_w"}, 64'(out_valid1), 64'd0);
    chk({tag, "_inst"}, 64'(inst0), 64'd0);
    chk({tag, "_addr"}, 64'(addr0), 64'd0);
    chk({tag, "_addr_w"}, 64'(addr1), 64'd0);
    chk({tag, "_err"}, 64'(err0), 64'd0);
  endtask

  initial begin
    int idx;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    k = 0; last_acc = 1'b0; n_emitted = 0; last_inst = 32'h0; last_err = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    send("addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093, 1'b0);
    chk("addi_addr", 64'(log0[0]), 64'd0);
    send("sw", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020_A423, 1'b0);
    send("beq", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 32'hFE00_0EE3, 1'b0);
    send("jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 32'h0010_00EF, 1'b0);
`ifdef INST_ENC_CHECK_EN
    send("b_odd", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 32'h0000_0013, 1'b1);
`else
    send("b_odd", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 32'h0000_0163, 1'b0);
`endif
    send("fmt7", 3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 32'd1, 32'h0000_0013, 1'b1);

    // Backpressure: three words offered with the consumer stalled.
    do_clear();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      set_fields(3'd1, 7'h13, 5'(idx + 1), 5'd2, 5'd0, 3'd0, 7'h00, 32'(idx * 7));
      in_valid = (idx < 3);
      run_cycle();
      if (acc) idx++;
    end
    chk("bp_accepts", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(in_ready0), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 12 && (idx < 3 || q.size() != 0); c++) begin
      set_fields(3'd1, 7'h13, 5'(idx + 1), 5'd2, 5'd0, 3'd0, 7'h00, 32'(idx * 7));
      in_valid = (idx < 3);
      run_cycle();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(log0.size()), 64'd3);
    for (int i = 0; i < 3 && i < log0.size(); i++) chk("bp_addr", 64'(log0[i]), 64'(i));

    // Wrap on the 2-bit counter instance.
    do_clear();
    for (int i = 0; i < 5; i++)
      send("wrap", 3'd4, 7'h37, 5'(i), 5'd0, 5'd0, 3'd0, 32'(i) << 12, (32'(i) << 12) | (32'(i) << 7) | 32'h37, 1'b0);
    for (int i = 0; i < 5 && i < log1.size(); i++) chk("wrap_addr_w", 64'(log1[i]), 64'((1 + i) % 4));

    // Clear with words in flight.
    out_ready = 1'b0;
    set_fields(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    in_valid = 1'b1;
    run_cycle(); run_cycle(); run_cycle();
    do_clear();
    chk("clear_out_valid", 64'(out_valid0), 64'd0);
    send("after_clear", 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 32'h0031_00B3, 1'b0);
    chk("after_clear_addr", 64'(log0[0]), 64'(BASE0));
    chk("after_clear_addr_w", 64'(log1[0]), 64'(BASE1));

    // Randomized traffic with backpressure and occasional clear.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
        0: imm = r;
        1: imm = 32'($urandom_range(0, 4200)) - 32'd2100;
        2: imm = {{11{r[21]}}, r[20:1], 1'b0};
        default: imm = r & 32'hFFFF_F000;
      endcase
      fmt = 3'($urandom_range(0, 7));
      opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 39) == 0);
      run_cycle();
    end
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) run_cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);

    // Asynchronous reset with words in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_fields(3'd1, 7'h13, 5'd9, 5'd9, 5'd0, 3'd0, 7'h00, 32'd1);
    run_cycle(); run_cycle(); run_cycle();
    chk("pre_reset_valid", 64'(out_valid0), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q.delete(); k = 0; last_acc = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    log0.delete(); log1.delete();
    send("post_reset", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093, 1'b0);
    chk("post_reset_addr", 64'(log0[0]), 64'd0);
    chk("post_reset_addr_w", 64'(log1[0]), 64'(BASE1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
